// File: rtl/fmc_apb_perf_counters.sv
// APB register block that reports FMC and APB root-bus activity over fixed windows of CLK_HZ cycles.
// Defining FMC_PERF_UPTIME_EN adds a 32-bit window counter at offset 0x28.
module fmc_apb_perf_counters #(
  parameter int unsigned CLK_HZ    = 125000000,
  parameter int unsigned CNT_WIDTH = 48
) (
  input  logic        pclk_i,
  input  logic        preset_n_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  input  logic        mon_penable_i,
  input  logic        mon_pready_i,
  input  logic        mon_pwrite_i,
  input  logic        fmc_cs_n_i,
  input  logic        fmc_nl_nadv_i
);

  localparam int unsigned NCNT = 5;
  localparam int unsigned TW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [TW-1:0]                  tick_cnt_q;
  logic                           tick;
  logic [NCNT-1:0]                en;
  logic [NCNT-1:0][CNT_WIDTH-1:0] raw_q;
  logic [NCNT-1:0][CNT_WIDTH-1:0] snap_q;
  logic [31:0]                    hi_shadow_q, hi_shadow_d;
  logic [31:0]                    prdata_q, prdata_d;
  logic                           pready_q;
  logic                           pslverr_q, pslverr_d;
  logic                           setup;
  logic                           clr;
  logic [7:0]                     off;
  logic                           unused_ok;

  // Index order: READS, WRITES, APB_ACTIVE, FMC_ACTIVE, FMC_ADDR.
  assign en = {!fmc_nl_nadv_i,
               !fmc_cs_n_i,
               mon_penable_i,
               mon_penable_i && mon_pready_i && mon_pwrite_i,
               mon_penable_i && mon_pready_i && !mon_pwrite_i};

  assign off       = paddr_i[7:0];
  assign setup     = psel_i && !penable_i;
  assign clr       = setup && pwrite_i && (off == 8'h2C) && pwdata_i[0];
  assign tick      = (tick_cnt_q == TICK_LAST);
  assign unused_ok = ^{paddr_i[31:8], pwdata_i[31:1], pstrb_i};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                    input logic             e);
    return (e && (v != CNT_MAX)) ? v + CNT_WIDTH'(1) : v;
  endfunction

`ifdef FMC_PERF_UPTIME_EN
  logic [31:0] uptime_q;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      uptime_q <= '0;
    end else if (clr) begin
      uptime_q <= '0;
    end else if (tick) begin
      uptime_q <= uptime_q + 32'd1;
    end
  end
`endif

  always_comb begin
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    hi_shadow_d = hi_shadow_q;
    if (pwrite_i) begin
      pslverr_d = (off != 8'h2C);
    end else if ((off[1:0] != 2'b00) || (off >= 8'h30)) begin
      pslverr_d = 1'b1;
    end else if (off < 8'h28) begin
      if (off[2]) begin
        prdata_d = hi_shadow_q;
      end else begin
        // Lo read latches the same pre-tick snapshot it returns, keeping the lo/hi pair coherent.
        for (int unsigned k = 0; k < NCNT; k++) begin
          if (off[5:3] == k[2:0]) begin
            prdata_d    = snap_q[k[2:0]][31:0];
            hi_shadow_d = 32'(snap_q[k[2:0]][CNT_WIDTH-1:32]);
          end
        end
      end
    end else if (off == 8'h28) begin
`ifdef FMC_PERF_UPTIME_EN
      prdata_d = uptime_q;
`else
      pslverr_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      hi_shadow_q <= '0;
      tick_cnt_q  <= '0;
      raw_q       <= '0;
      snap_q      <= '0;
    end else begin
      pready_q  <= setup;
      pslverr_q <= setup && pslverr_d;
      prdata_q  <= setup ? prdata_d : '0;
      if (setup) begin
        hi_shadow_q <= hi_shadow_d;
      end
      // A clear in the tick cycle wins over the snapshot update.
      if (clr) begin
        tick_cnt_q <= '0;
        raw_q      <= '0;
        snap_q     <= '0;
      end else begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        for (int unsigned k = 0; k < NCNT; k++) begin
          if (tick) begin
            snap_q[k[2:0]] <= sat_inc(raw_q[k[2:0]], en[k[2:0]]);
            raw_q[k[2:0]]  <= '0;
          end else begin
            raw_q[k[2:0]]  <= sat_inc(raw_q[k[2:0]], en[k[2:0]]);
          end
        end
      end
    end
  end

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule
